// File: rtl/dir_cmd_parser.sv
// dir_cmd_parser: assembles received bytes into CMD/DATA write frames for the
// direction-register decoder and emits a one-cycle write strobe per good frame.
// Optional feature macro: DIR_CMD_CHECKSUM_EN adds a CHK byte after DATA
// (expected CHK = CMD ^ DATA ^ 8'hA5).
//
// Handshake: rx_valid is a one-cycle qualifier for rx_data with no back-pressure;
// every pulse is consumed in the cycle it is presented. strob_out and frame_err
// are one-cycle pulses and are never high together.
module dir_cmd_parser #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [1:0] addr_out,
    output logic       choose_dir_reg,
    output logic       choose_out_reg,
    output logic [7:0] data_out,
    output logic       strob_out,
    output logic       frame_err
);

    localparam int            CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
`ifdef DIR_CMD_CHECKSUM_EN
        WAIT_CHK  = 2'd2,
`endif
        STROBE    = 2'd3
    } state_t;

    // state_q is the observable FSM state for checkers bound to this block.
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q;
    logic          dir_q;
    logic          opcode_ok;
    logic          load_cmd;
    logic          commit;
    logic          err;
    logic          timed_out;
    logic [7:0]    commit_data;

`ifdef DIR_CMD_CHECKSUM_EN
    logic [7:0]    cmd_q;
    logic [7:0]    data_q;
    logic          load_data;
    logic          chk_ok;

    assign chk_ok      = (rx_data == (cmd_q ^ data_q ^ 8'hA5));
    assign commit_data = data_q;
`else
    // CMD bits [3:2] are reserved and carry no meaning in this build.
    logic          unused_cmd_bits;

    assign unused_cmd_bits = ^rx_data[3:2];
    assign commit_data     = rx_data;
`endif

    assign opcode_ok = (rx_data[7:4] == 4'h1) || (rx_data[7:4] == 4'h2);
    assign timed_out = (cnt_q == TIMEOUT_CNT);

    // Next-state, inter-byte timeout and datapath control decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        load_cmd = 1'b0;
        commit   = 1'b0;
        err      = 1'b0;
`ifdef DIR_CMD_CHECKSUM_EN
        load_data = 1'b0;
`endif
        case (state_q)
            // STROBE behaves as IDLE so a CMD byte arriving right after a frame is kept.
            IDLE, STROBE: begin
                state_d = IDLE;
                if (rx_valid) begin
                    if (opcode_ok) begin
                        load_cmd = 1'b1;
                        state_d  = WAIT_DATA;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                if (rx_valid) begin
`ifdef DIR_CMD_CHECKSUM_EN
                    load_data = 1'b1;
                    state_d   = WAIT_CHK;
`else
                    commit  = 1'b1;
                    state_d = STROBE;
`endif
                end else if (timed_out) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef DIR_CMD_CHECKSUM_EN
            WAIT_CHK: begin
                if (rx_valid) begin
                    if (chk_ok) begin
                        commit  = 1'b1;
                        state_d = STROBE;
                    end else begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timed_out) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // FSM state and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Frame capture and output registers; outputs move only on a committed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            dir_q          <= 1'b0;
            addr_out       <= '0;
            choose_dir_reg <= 1'b0;
            choose_out_reg <= 1'b0;
            data_out       <= '0;
            strob_out      <= 1'b0;
            frame_err      <= 1'b0;
`ifdef DIR_CMD_CHECKSUM_EN
            cmd_q          <= '0;
            data_q         <= '0;
`endif
        end else begin
            strob_out <= commit;
            frame_err <= err;
            if (load_cmd) begin
                idx_q <= rx_data[1:0];
                dir_q <= (rx_data[7:4] == 4'h1);
`ifdef DIR_CMD_CHECKSUM_EN
                cmd_q <= rx_data;
`endif
            end
`ifdef DIR_CMD_CHECKSUM_EN
            if (load_data) begin
                data_q <= rx_data;
            end
`endif
            if (commit) begin
                addr_out       <= idx_q;
                choose_dir_reg <= dir_q;
                choose_out_reg <= ~dir_q;
                data_out       <= commit_data;
            end
        end
    end

endmodule
